config_regfile: RTL and testbench

Parametrised UART-driven configuration register file and the generalised successor to the cube's single-byte nibble config decoder. It parses a framed byte stream (header + multi-byte payload) from the UART receiver into `NUM_REGS` registers of `REG_W` bits each, and returns register contents on a byte-wide TX handshake. It sits between the UART RX/TX and the cube's mode/brightness/animation logic, which consume the flat `regs` vector and the per-register write strobes.

---
 rtl/config_regfile.sv | 215 +++++++++++++++++++++
 tb/tb_config_regfile.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/config_regfile.sv
// rtl/config_regfile.sv - UART-framed configuration register file with byte-wide readback
module config_regfile #(
    parameter int                         NUM_REGS   = 8,
    parameter int                         REG_W      = 16,
    parameter logic [NUM_REGS*REG_W-1:0]  RESET_VALS = '0,
    parameter int                         TIMEOUT    = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [NUM_REGS*REG_W-1:0] regs,
    output logic [NUM_REGS-1:0]       reg_wr_stb,
    output logic                      busy,
    output logic [7:0]                err_cnt
);

    // Payload bytes per frame and the byte-aligned width that holds them.
    localparam int         NB       = (REG_W + 7) / 8;
    localparam int         AW       = 8 * NB;
    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [6:0] ERR_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [6:0]        addr_q;
    logic [1:0]        idx_q;
    logic [TW-1:0]     tmo_q;
    logic [AW-1:0]     asm_q;
    logic [AW-1:0]     tx_shift_q;
    logic [REG_W-1:0]  reg_q [NUM_REGS];

    logic              hdr_acc;
    logic              hdr_addr_ok;
    logic              addr_q_ok;
    logic              wr_byte;
    logic              last_byte;
    logic              tmo_hit;
    logic              tx_hs;
    logic              last_tx;
    logic              err_evt;
    logic              err_clr;
    logic [AW-1:0]     asm_next;
    logic [AW-1:0]     rd_val;
    logic [NUM_REGS-1:0] wr_onehot;

    // Frame decode: which events happen this cycle.
    always_comb begin
        hdr_acc     = (state_q == S_IDLE) && rx_valid;
        hdr_addr_ok = ({1'b0, rx_data[6:0]} < 8'(NUM_REGS));
        addr_q_ok   = ({1'b0, addr_q} < 8'(NUM_REGS));
        wr_byte     = (state_q == S_WDATA) && rx_valid;
        last_byte   = wr_byte && (idx_q == 2'(NB - 1));
        tmo_hit     = (state_q == S_WDATA) && !rx_valid && (tmo_q == TW'(TIMEOUT - 1));
        tx_hs       = (state_q == S_RDATA) && tx_ready;
        last_tx     = tx_hs && (idx_q == 2'(NB - 1));
        asm_next    = (asm_q << 8) | AW'(rx_data);
        err_clr     = last_byte && (addr_q == ERR_ADDR);
        err_evt     = (last_byte && !addr_q_ok && (addr_q != ERR_ADDR))
                    || tmo_hit
                    || (hdr_acc && !rx_data[7] && !hdr_addr_ok && (rx_data[6:0] != ERR_ADDR))
                    || ((state_q == S_RDATA) && rx_valid);
    end

    // Readback source selected by the header address; unknown addresses read as zero.
    always_comb begin
        rd_val = '0;
        if (rx_data[6:0] == ERR_ADDR) begin
            rd_val = AW'(err_cnt);
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rx_data[6:0] == 7'(i)) begin
                    rd_val[REG_W-1:0] = reg_q[i];
                end
            end
        end
    end

    // One-hot register write enable on the commit of a frame to a real register.
    always_comb begin
        wr_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_onehot[i] = last_byte && (addr_q == 7'(i));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    state_d = rx_data[7] ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                if (last_byte || tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (last_tx) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame datapath: address latch, byte index, payload assembly, timeout and TX shifter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            asm_q      <= '0;
            tx_shift_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        addr_q <= rx_data[6:0];
                        idx_q  <= '0;
                        tmo_q  <= '0;
                        asm_q  <= '0;
                        if (!rx_data[7]) begin
                            tx_shift_q <= rd_val;
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        asm_q <= asm_next;
                        tmo_q <= '0;
                        idx_q <= last_byte ? 2'd0 : idx_q + 2'd1;
                    end else if (tmo_hit) begin
                        idx_q <= '0;
                        tmo_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_RDATA: begin
                    if (tx_ready) begin
                        tx_shift_q <= tx_shift_q << 8;
                        idx_q      <= last_tx ? 2'd0 : idx_q + 2'd1;
                    end
                end
                default: begin
                    idx_q <= '0;
                    tmo_q <= '0;
                end
            endcase
        end
    end

    // Register storage and the one-cycle write strobe that follows each commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= RESET_VALS[i*REG_W +: REG_W];
            end
            reg_wr_stb <= '0;
        end else begin
            reg_wr_stb <= wr_onehot;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_onehot[i]) begin
                    reg_q[i] <= asm_next[REG_W-1:0];
                end
            end
        end
    end

    // Saturating protocol error counter; a clear beats any simultaneous error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    // Flatten storage onto the consumer-facing vector.
    always_comb begin
        regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i*REG_W +: REG_W] = reg_q[i];
        end
    end

    assign tx_data  = tx_shift_q[AW-1 -: 8];
    assign tx_valid = (state_q == S_RDATA);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_config_regfile.sv
// tb/tb_config_regfile.sv - randomized self-checking bench for config_regfile
module tb_config_regfile;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 16;
    localparam int TIMEOUT  = 20;
    localparam logic [127:0] RV = 128'h0000_0000_0000_0000_0000_0000_000F_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [127:0] regs;
    logic [7:0]   reg_wr_stb;
    logic         busy;
    logic [7:0]   err_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_regs [NUM_REGS];
    int          m_err;

    config_regfile #(
        .NUM_REGS   (NUM_REGS),
        .REG_W      (REG_W),
        .RESET_VALS (RV),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .regs       (regs),
        .reg_wr_stb (reg_wr_stb),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] m_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*16 +: 16] = m_regs[i];
        return f;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = RV[i*16 +: 16];
        m_err = 0;
    endtask

    task automatic m_bump();
        if (m_err < 255) m_err = m_err + 1;
    endtask

    // Presents one byte for exactly one clock; called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [15:0] v);
        logic [7:0] es;
        send_byte({1'b1, a});
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy a=%h got=%b exp=1", a, busy); end
        send_byte(v[15:8]);
        send_byte(v[7:0]);
        es = '0;
        if (a < 7'd8) begin
            m_regs[a[2:0]] = v;
            es[a[2:0]] = 1'b1;
        end else if (a == 7'h7F) begin
            m_err = 0;
        end else begin
            m_bump();
        end
        total++;
        if (reg_wr_stb !== es) begin bad++; $display("FAIL wr_stb a=%h got=%h exp=%h", a, reg_wr_stb, es); end
        total++;
        if (regs !== m_flat()) begin bad++; $display("FAIL wr_regs a=%h got=%h exp=%h", a, regs, m_flat()); end
        total++;
        if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL wr_err a=%h got=%0d exp=%0d", a, err_cnt, m_err); end
    endtask

    task automatic do_read(input logic [6:0] a, input int delay, input bit inject);
        logic [15:0] exp;
        logic [7:0]  expb;
        if (a < 7'd8) exp = m_regs[a[2:0]];
        else if (a == 7'h7F) exp = {8'h00, 8'(m_err)};
        else begin exp = 16'h0000; m_bump(); end
        send_byte({1'b0, a});
        if (inject) begin
            send_byte(8'($urandom));
            m_bump();
        end
        for (int k = 0; k < 2; k++) begin
            expb = (k == 0) ? exp[15:8] : exp[7:0];
            for (int d = 0; d < delay; d++) begin
                total++;
                if (tx_valid !== 1'b1 || tx_data !== expb) begin
                    bad++;
                    $display("FAIL rd_hold a=%h k=%0d got=%b/%h exp=1/%h", a, k, tx_valid, tx_data, expb);
                end
                @(negedge clk);
            end
            total++;
            if (tx_valid !== 1'b1 || tx_data !== expb) begin
                bad++;
                $display("FAIL rd_byte a=%h k=%0d got=%b/%h exp=1/%h", a, k, tx_valid, tx_data, expb);
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rd_end a=%h got=%b/%b exp=0/0", a, tx_valid, busy);
        end
        total++;
        if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL rd_err a=%h got=%0d exp=%0d", a, err_cnt, m_err); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        total++;
        if (regs !== RV) begin bad++; $display("FAIL reset_regs got=%h exp=%h", regs, RV); end
        total++;
        if (err_cnt !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ctl got=%h/%b exp=0/0", err_cnt, busy); end
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || reg_wr_stb !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx got=%b/%h/%h exp=0/00/00", tx_valid, tx_data, reg_wr_stb);
        end
    endtask

    task automatic test_write();
        do_write(7'd2, 16'hABCD);
        @(negedge clk);
        total++;
        if (reg_wr_stb !== 8'h00) begin bad++; $display("FAIL stb_pulse got=%h exp=00", reg_wr_stb); end
    endtask

    task automatic test_read_backpressure();
        do_read(7'd2, 5, 1'b0);
        do_read(7'd1, 0, 1'b0);
    endtask

    task automatic test_timeout();
        send_byte(8'h83);
        send_byte(8'h11);
        repeat (TIMEOUT + 3) @(negedge clk);
        m_bump();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%b exp=0", busy); end
        total++;
        if (regs !== m_flat()) begin bad++; $display("FAIL tmo_regs got=%h exp=%h", regs, m_flat()); end
        total++;
        if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL tmo_err got=%0d exp=%0d", err_cnt, m_err); end
        do_write(7'd3, 16'h5A5A);
    endtask

    task automatic test_errors();
        do_write(7'h10, 16'h1234);
        do_read(7'h7F, 0, 1'b0);
        do_read(7'h55, 1, 1'b0);
        do_write(7'h7F, 16'h0000);
        for (int i = 0; i < 300; i++) begin
            do_write(7'($urandom_range(8, 126)), 16'($urandom));
        end
        total++;
        if (err_cnt !== 8'd255) begin bad++; $display("FAIL err_sat got=%0d exp=255", err_cnt); end
        do_read(7'h7F, 2, 1'b0);
        do_write(7'h7F, 16'hFFFF);
    endtask

    task automatic test_rx_during_read();
        do_read(7'd2, 2, 1'b1);
        do_read(7'h7F, 1, 1'b1);
    endtask

    task automatic test_random_back_to_back();
        int op;
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 9));
            if (op < 4) do_write(7'($urandom_range(0, 7)), 16'($urandom));
            else if (op == 4) do_write(7'($urandom_range(8, 126)), 16'($urandom));
            else if (op == 5) do_write(7'h7F, 16'($urandom));
            else if (op < 8) do_read(7'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom));
            else if (op == 8) do_read(7'h7F, int'($urandom_range(0, 2)), 1'b0);
            else do_read(7'($urandom_range(8, 126)), 0, 1'b0);
        end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h81);
        send_byte(8'h12);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        total++;
        if (regs !== RV || reg_wr_stb !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset got=%h/%h exp=%h/00", regs, reg_wr_stb, RV);
        end
        total++;
        if (busy !== 1'b0 || err_cnt !== 8'd0) begin bad++; $display("FAIL mid_reset_ctl got=%b/%0d exp=0/0", busy, err_cnt); end
        do_write(7'd1, 16'hC0DE);
        do_read(7'd1, 0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        m_reset();
        @(negedge clk);
        test_reset();
        test_write();
        test_read_backpressure();
        test_timeout();
        test_errors();
        test_rx_during_read();
        test_random_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
